imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
Instruction-memory stage sitting directly upstream of the single-cycle datapath. It supplies inst for the datapath's pc and holds the CPU in reset while a program image arrives as a byte stream over a valid/ready interface. After the declared word count is loaded, it releases cpu_reset and serves fetches. Holds the instruction RAM plus a load FSM with a byte assembler and word counter.

Parameters:
WIDTH, 32, pc and instruction width; fixed at 32 (4 bytes per word)
DEPTH_BITS, 6, log2 of RAM depth in words (default 64 words)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; sampled on rising clk edge
rx_valid  input  1  byte-stream valid
rx_data  input  8  byte-stream data
rx_ready  output  1  loader can accept a byte this cycle
pc  input  WIDTH  fetch address from datapath
inst  output  WIDTH  instruction at pc
cpu_reset  output  1  reset to datapath; high until load completes
loaded_words  output  DEPTH_BITS+1  words written so far
err  output  1  sticky: declared length exceeds 2^DEPTH_BITS

Behaviour:
- Transfer: a byte is accepted on a rising edge where rx_valid && rx_ready. No other cycle consumes a byte. rx_data is ignored when not accepted.
- States:
  - LEN0: accept the count low byte, then go to LEN1.
  - LEN1: accept the count high byte.
    - N == 0: go to RUN.
    - N > 2^DEPTH_BITS: go to ERR and set err.
    - Otherwise: go to DATA.
  - DATA: assemble each word little-endian. Byte k (0..3) goes to bits [8k+7:8k]. On the 4th accepted byte, write the word to RAM[word_addr] in that same edge. Then increment word_addr and loaded_words and clear the byte index. When loaded_words reaches N, go to RUN.
  - RUN: terminal until reset.
  - ERR: terminal until reset.
- rx_ready:
  - Combinational: high in LEN0, LEN1 and DATA; low in RUN and ERR.
  - Forced low while reset is high.
- cpu_reset:
  - Registered. High in every state except RUN.
  - Falls on the edge after entering RUN, i.e. one cycle after the final word is written. The datapath therefore never fetches a word written in the same cycle.
- inst:
  - RUN: inst = RAM[pc[DEPTH_BITS+1:2]], combinational read.
  - pc[1:0] is ignored. Upper pc bits are truncated, so addresses wrap modulo the RAM depth.
  - All other states: inst = 0 (treated as a nop).
- Reset behaviour (on the edge with reset high):
  - Next state is LEN0.
  - word_addr, byte index, N and loaded_words are cleared to 0.
  - err is cleared to 0 and cpu_reset is set to 1.
  - RAM contents are NOT cleared.
- Reset mid-load: the partially assembled word is discarded, and the next accepted byte is the count low byte.
- Simultaneous reset and rx_valid: reset wins and no byte is accepted.
- rx_valid held high continuously: one byte is taken per cycle with no bubbles. Loading N words takes exactly 2+4N accepting cycles.
- Exactly full load (N == 2^DEPTH_BITS): legal; the last write goes to the top address. loaded_words is DEPTH_BITS+1 bits wide so it can represent this count.
- Unused RAM words beyond N keep their prior contents.

Decomposition:
- Shared package:
  - state encoding LEN0/LEN1/DATA/RUN/ERR
  - BYTES_PER_WORD = 4
  - NOP_INST = 32'h0
- Sub-module imem_ram (parameters WIDTH, DEPTH_BITS):
  - synchronous write port (we, waddr, wdata)
  - combinational read port (raddr, rdata)
- FSM, byte assembler and counters live in imem_boot_loader.

Test Plan:
- Reset, then stream 02 00 | 78 56 34 12 | EF BE AD DE with rx_valid held high → RAM[0]=0x12345678, RAM[1]=0xDEADBEEF. cpu_reset falls exactly one cycle after the last byte is accepted. Then pc=0 gives inst=0x12345678 and pc=4 gives 0xDEADBEEF.
- Same image with rx_valid toggled every other cycle → identical RAM contents. Bytes are taken only on valid&&ready cycles and loaded_words steps 0→1→2.
- Count 00 00 → RUN entered after 2 bytes, cpu_reset low on the next edge, rx_ready low afterwards, loaded_words=0.
- Count 41 00 (65 > 64) → err=1, rx_ready=0, cpu_reset stays 1, inst=0. Reset clears err and returns to LEN0.
- Assert reset after 1 data word plus 2 bytes of the second → RAM[0] retained, partial word dropped. A fresh load of count 01 00 followed by AA BB CC DD gives RAM[0]=0xDDCCBBAA.
- In RUN, pc=0x101 and pc=0x100 both fetch RAM[0] for DEPTH_BITS=6 (index bits [7:2] wrap to 0, low bits ignored). Bytes driven in RUN are not accepted.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: load states
// and constants for assembling 32-bit words out of a byte stream.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    RUN,
    ERR
  } load_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam logic [31:0] NOP_INST = 32'h0;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: one synchronous write port for the loader and one
// combinational read port for the datapath fetch.
module imem_ram #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_BITS-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [1 << DEPTH_BITS];

  // Store a completed word; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader in front of the single-cycle datapath: receives a 16-bit word
// count and a little-endian word image over a byte stream, fills the
// instruction RAM, then releases cpu_reset and serves fetches.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic [WIDTH-1:0]      pc,
  output logic [WIDTH-1:0]      inst,
  output logic                  cpu_reset,
  output logic [DEPTH_BITS:0]   loaded_words,
  output logic                  err
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  load_state_t           state;
  logic [23:0]           word_buf;
  logic [1:0]            byte_idx;
  logic [DEPTH_BITS-1:0] word_addr;
  logic [15:0]           word_count;
  logic                  accept;
  logic                  ram_we;
  logic [WIDTH-1:0]      ram_rdata;
  logic [16:0]           len_next;
  logic [16:0]           words_next;
  logic                  unused_pc_bits;

  // Bytes are only taken while loading and never on a reset cycle
  assign rx_ready   = !reset && (state == LEN0 || state == LEN1 || state == DATA);
  assign accept     = rx_valid && rx_ready;
  assign ram_we     = accept && (state == DATA) && (byte_idx == 2'd3);
  assign len_next   = {1'b0, rx_data, word_count[7:0]};
  assign words_next = 17'(loaded_words) + 17'd1;

  // The word index ignores the byte offset and wraps modulo the RAM depth
  assign unused_pc_bits = ^{pc[WIDTH-1:DEPTH_BITS+2], pc[1:0]};

  imem_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (word_addr),
    .wdata ({rx_data, word_buf}),
    .raddr (pc[DEPTH_BITS+1:2]),
    .rdata (ram_rdata)
  );

  assign inst = (state == RUN) ? ram_rdata : NOP_INST;

  // Load FSM: length bytes, then word assembly until the count is reached
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LEN0;
      word_addr    <= '0;
      byte_idx     <= '0;
      word_count   <= '0;
      loaded_words <= '0;
      err          <= 1'b0;
      cpu_reset    <= 1'b1;
    end else begin
      cpu_reset <= (state != RUN);
      if (accept) begin
        case (state)
          LEN0: begin
            word_count[7:0] <= rx_data;
            state           <= LEN1;
          end
          LEN1: begin
            word_count[15:8] <= rx_data;
            if (len_next == 17'd0) begin
              state <= RUN;
            end else if (len_next > 17'(DEPTH)) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              2'd3: begin
                word_addr    <= word_addr + 1'b1;
                loaded_words <= loaded_words + 1'b1;
                if (words_next == {1'b0, word_count}) begin
                  state <= RUN;
                end
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised and directed bench for imem_boot_loader with a stream-level
// reference model.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic [31:0] pc = 32'h0;
  logic [31:0] inst;
  logic        cpu_reset;
  logic [6:0]  loaded_words;
  logic        err;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  // Reference model: everything follows from the bytes accepted since reset
  int          m_nbytes = 0;
  int          m_n = 0;
  int          m_words = 0;
  bit          m_err = 0;
  bit          m_run = 0;
  bit          m_cpu_reset = 1;
  logic [31:0] m_cur = 32'h0;
  logic [31:0] m_ram [64];
  bit          m_valid [64];

  imem_boot_loader #(.WIDTH(32), .DEPTH_BITS(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .pc           (pc),
    .inst         (inst),
    .cpu_reset    (cpu_reset),
    .loaded_words (loaded_words),
    .err          (err)
  );

  always #5 clk = ~clk;

  function automatic bit model_ready();
    return !reset && !(m_run || m_err);
  endfunction

  // Advance the model with what the DUT sees on this rising edge
  always @(posedge clk) begin
    bit prev_run;
    int k;
    prev_run = m_run;
    if (reset) begin
      m_nbytes    = 0;
      m_n         = 0;
      m_words     = 0;
      m_err       = 0;
      m_run       = 0;
      m_cpu_reset = 1;
    end else begin
      if (rx_valid && model_ready()) begin
        if (m_nbytes == 0) m_n = int'(rx_data);
        else if (m_nbytes == 1) m_n = m_n + 256 * int'(rx_data);
        else begin
          k = (m_nbytes - 2) % 4;
          m_cur[8*k +: 8] = rx_data;
          if (k == 3) begin
            m_ram[m_words]   = m_cur;
            m_valid[m_words] = 1;
            m_words++;
          end
        end
        m_nbytes++;
        if (m_nbytes == 2) m_err = (m_n > 64);
        m_run = (m_nbytes >= 2) && !m_err && (m_words == m_n);
      end
      m_cpu_reset = !prev_run;
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge clk) begin
    logic [31:0] exp_inst;
    int idx;
    if (check_en) begin
      checks++;
      if (rx_ready !== model_ready()) begin
        errors++;
        $display("[TB] FAIL rx_ready: got %0b expected %0b at %0t", rx_ready, model_ready(), $time);
      end
      checks++;
      if (cpu_reset !== m_cpu_reset) begin
        errors++;
        $display("[TB] FAIL cpu_reset: got %0b expected %0b at %0t", cpu_reset, m_cpu_reset, $time);
      end
      checks++;
      if (err !== m_err) begin
        errors++;
        $display("[TB] FAIL err: got %0b expected %0b at %0t", err, m_err, $time);
      end
      checks++;
      if (loaded_words !== 7'(m_words)) begin
        errors++;
        $display("[TB] FAIL loaded_words: got %0d expected %0d at %0t", loaded_words, m_words, $time);
      end
      idx = int'(pc[7:2]);
      if (!m_run || m_valid[idx]) begin
        exp_inst = m_run ? m_ram[idx] : 32'h0;
        checks++;
        if (inst !== exp_inst) begin
          errors++;
          $display("[TB] FAIL inst: pc=%h got %h expected %h at %0t", pc, inst, exp_inst, $time);
        end
      end
    end
  end

  // Drive inputs for one cycle and return just after the consuming edge
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    rx_valid = v;
    rx_data  = d;
    reset    = r;
    @(posedge clk);
    #1;
  endtask

  // Literal expectation that pins the model independently
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 8'hA5, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic sendBytes(input logic [7:0] bytes [], input bit toggle);
    foreach (bytes[i]) begin
      if (toggle) applyStimulus(1'b0, 8'($urandom), 1'b0);
      applyStimulus(1'b1, bytes[i], 1'b0);
    end
  endtask

  logic [7:0] img [];

  initial begin
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    check_en = 1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("reset_cpu_reset", 32'(cpu_reset), 32'h1);
    checkOutput("reset_rx_ready", 32'(rx_ready), 32'h1);
    checkOutput("reset_loaded", 32'(loaded_words), 32'h0);

    // Two-word image with valid held high
    img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    sendBytes(img, 0);
    checkOutput("last_byte_cpu_reset_high", 32'(cpu_reset), 32'h1);
    checkOutput("run_rx_ready_low", 32'(rx_ready), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("cpu_reset_falls", 32'(cpu_reset), 32'h0);
    pc = 32'h0; #1;
    checkOutput("fetch_pc0", inst, 32'h12345678);
    pc = 32'h4; #1;
    checkOutput("fetch_pc4", inst, 32'hDEADBEEF);
    checkOutput("loaded_two", 32'(loaded_words), 32'h2);

    // Same image with valid toggled
    pc = 32'h0;
    doReset();
    sendBytes(img, 1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    pc = 32'h4; #1;
    checkOutput("toggle_fetch_pc4", inst, 32'hDEADBEEF);

    // Zero-length image
    doReset();
    img = '{8'h00, 8'h00};
    sendBytes(img, 0);
    applyStimulus(1'b1, 8'h11, 1'b0);
    checkOutput("zero_cpu_reset", 32'(cpu_reset), 32'h0);
    checkOutput("zero_loaded", 32'(loaded_words), 32'h0);

    // Oversized count
    doReset();
    img = '{8'h41, 8'h00};
    sendBytes(img, 0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    checkOutput("oversize_err", 32'(err), 32'h1);
    checkOutput("oversize_inst", inst, 32'h0);
    checkOutput("oversize_cpu_reset", 32'(cpu_reset), 32'h1);
    doReset();
    checkOutput("err_cleared", 32'(err), 32'h0);

    // Reset in the middle of the second word, then a fresh one-word load
    img = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h55, 8'h66};
    sendBytes(img, 0);
    doReset();
    img = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    sendBytes(img, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    pc = 32'h0; #1;
    checkOutput("reload_word0", inst, 32'hDDCCBBAA);
    pc = 32'h101; #1;
    checkOutput("wrap_pc101", inst, 32'hDDCCBBAA);
    pc = 32'h100; #1;
    checkOutput("wrap_pc100", inst, 32'hDDCCBBAA);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
    checkOutput("run_ignores_bytes", 32'(loaded_words), 32'h1);

    // Randomised loads, including an exactly full and an oversized image
    for (int iter = 0; iter < 8; iter++) begin
      int n;
      int len;
      int sent;
      int guard;
      logic v;
      n = (iter == 0) ? 64 : (iter == 1) ? int'($urandom_range(65, 300)) : int'($urandom_range(0, 12));
      len = (n > 64) ? 2 : 2 + 4 * n;
      img = new[len];
      img[0] = 8'(n);
      img[1] = 8'(n >> 8);
      for (int i = 2; i < len; i++) img[i] = 8'($urandom);
      doReset();
      sent = 0;
      guard = 0;
      while (sent < len && guard < 3000) begin
        v = ($urandom_range(0, 9) < 7);
        pc = $urandom;
        if (v && model_ready()) begin
          applyStimulus(1'b1, img[sent], 1'b0);
          sent++;
        end else begin
          applyStimulus(v, 8'($urandom), 1'b0);
        end
        guard++;
      end
      checks++;
      if (sent != len) begin
        errors++;
        $display("[TB] FAIL stream_timeout: sent %0d expected %0d", sent, len);
      end
      for (int i = 0; i < 40; i++) begin
        pc = $urandom;
        applyStimulus(1'(($urandom_range(0, 1))), 8'($urandom), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
